// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data-memory port between CPU M-stage and DMA
//
// Purpose:
//   Two-master arbiter for the single data-memory port. Master 0 is the CPU
//   M-stage and master 1 is the DMA engine. A free port is granted in the same
//   cycle it is requested, so no latency is added. The winner keeps the port
//   through memory wait states, and also through locked DMA bursts of up to
//   BURST_MAX beats. A master that has been denied for STARVE_LIMIT cycles wins
//   the next free arbitration.
//
// Configuration macro:
//   ARB_CPU_PRIO_EN - simultaneous free-cycle requests go to the CPU (fixed
//                     priority) instead of round-robin.
//
// Ports:
//   clk, reset                          clock (rising edge); synchronous active-low reset
//   cpu_req/addr/wdata/byteen           CPU access request (byteen 0 = read)
//   cpu_ack, cpu_rdata, cpu_stall       CPU completion, read data, stall
//   dma_req/lock/addr/wdata/byteen      DMA access request, plus burst lock
//   dma_ack, dma_rdata                  DMA completion, read data
//   mem_addr/wdata/byteen               muxed memory request (word-aligned address)
//   mem_rdata, mem_ready                memory read data and completion
module dmem_port_arbiter #(
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2,
    LOCK_DMA = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] cpu_starve_q, cpu_starve_d;
  logic [SW-1:0] dma_starve_q, dma_starve_d;

  logic gnt_cpu, gnt_dma;
  logic free_arb, abort, pick_dma;
  logic cpu_starved, dma_starved;
  logic int_cpu_ack, int_dma_ack;
  logic out_cpu, out_dma;

  assign cpu_starved = cpu_starve_q >= STARVE_MAX;
  assign dma_starved = dma_starve_q >= STARVE_MAX;

  // Grant decision
  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_dma  = 1'b0;
    free_arb = 1'b0;
    abort    = 1'b0;
    pick_dma = 1'b0;

    case (state_q)
      IDLE:     free_arb = 1'b1;
      BUSY_CPU: begin
        if (cpu_req) gnt_cpu = 1'b1;
        else         abort   = 1'b1;
      end
      BUSY_DMA: begin
        if (dma_req) gnt_dma = 1'b1;
        else         abort   = 1'b1;
      end
      LOCK_DMA: begin
        // A dropped dma_req releases the lock, and the cycle behaves as IDLE.
        if (dma_req) gnt_dma  = 1'b1;
        else         free_arb = 1'b1;
      end
      default:  free_arb = 1'b1;
    endcase

    if (free_arb) begin
      if (cpu_req && dma_req) begin
        if (cpu_starved && !dma_starved) begin
          pick_dma = 1'b0;
        end else if (dma_starved && !cpu_starved) begin
          pick_dma = 1'b1;
        end else begin
`ifdef ARB_CPU_PRIO_EN
          pick_dma = 1'b0;
`else
          pick_dma = (last_gnt_q == GNT_CPU);
`endif
        end
        gnt_cpu = !pick_dma;
        gnt_dma = pick_dma;
      end else begin
        gnt_cpu = cpu_req;
        gnt_dma = dma_req;
      end
    end
  end

  assign int_cpu_ack = gnt_cpu & mem_ready;
  assign int_dma_ack = gnt_dma & mem_ready;

  // Next-state, burst and starvation bookkeeping
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;

    if (abort) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (gnt_cpu) begin
      beat_cnt_d = '0;
      if (mem_ready) begin
        state_d    = IDLE;
        last_gnt_d = GNT_CPU;
      end else begin
        state_d = BUSY_CPU;
      end
    end else if (gnt_dma) begin
      if (mem_ready) begin
        last_gnt_d = GNT_DMA;
        // beat_cnt_q < BURST_MAX-1 is beat_cnt+1 < BURST_MAX without overflow.
        if (dma_lock && (beat_cnt_q < BURST_LAST)) begin
          state_d    = LOCK_DMA;
          beat_cnt_d = beat_cnt_q + BW'(1);
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end else begin
        state_d = BUSY_DMA;
      end
    end else begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end

    cpu_starve_d = cpu_starve_q;
    if (!cpu_req || int_cpu_ack) begin
      cpu_starve_d = '0;
    end else if (!gnt_cpu && (cpu_starve_q < STARVE_MAX)) begin
      cpu_starve_d = cpu_starve_q + SW'(1);
    end

    dma_starve_d = dma_starve_q;
    if (!dma_req || int_dma_ack) begin
      dma_starve_d = '0;
    end else if (!gnt_dma && (dma_starve_q < STARVE_MAX)) begin
      dma_starve_d = dma_starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_gnt_q   <= GNT_DMA;
      beat_cnt_q   <= '0;
      cpu_starve_q <= '0;
      dma_starve_q <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      beat_cnt_q   <= beat_cnt_d;
      cpu_starve_q <= cpu_starve_d;
      dma_starve_q <= dma_starve_d;
    end
  end

  // All outputs are held at 0 while reset is asserted.
  assign out_cpu = gnt_cpu & reset;
  assign out_dma = gnt_dma & reset;

  assign mem_addr   = out_cpu ? (cpu_addr & 32'hFFFF_FFFC) :
                      out_dma ? (dma_addr & 32'hFFFF_FFFC) : 32'h0;
  assign mem_wdata  = out_cpu ? cpu_wdata : out_dma ? dma_wdata : 32'h0;
  assign mem_byteen = out_cpu ? cpu_byteen : out_dma ? dma_byteen : 4'h0;

  assign cpu_ack   = out_cpu & mem_ready;
  assign dma_ack   = out_dma & mem_ready;
  assign cpu_rdata = cpu_ack ? mem_rdata : 32'h0;
  assign dma_rdata = dma_ack ? mem_rdata : 32'h0;
  assign cpu_stall = reset & cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_ack, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_byteen (dma_byteen),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // Small word memory behind the port: combinational read, byte-lane writes.
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_ready && (mem_byteen != 4'h0)) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteen[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    reset = 1'b0; mem_ready = 1'b1;
    cpu_req = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'h0; cpu_byteen = 4'hF;
    dma_req = 1'b1; dma_lock = 1'b0; dma_addr = 32'h8; dma_wdata = 32'h0; dma_byteen = 4'hF;

    // Reset: outputs forced low even with requests pending
    sample();
    check("rst_cpu_ack",   {31'b0, cpu_ack},   32'h0);
    check("rst_dma_ack",   {31'b0, dma_ack},   32'h0);
    check("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    check("rst_byteen",    {28'b0, mem_byteen}, 32'h0);
    check("rst_addr",      mem_addr,            32'h0);
    next_cycle();
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    next_cycle();

    // Both request after reset: last_gnt=DMA so CPU first, DMA next
    cpu_req = 1'b1; cpu_addr = 32'h4; cpu_byteen = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h8; dma_byteen = 4'h0;
    sample();
    check("t2_cpu_ack",   {31'b0, cpu_ack}, 32'h1);
    check("t2_dma_ack0",  {31'b0, dma_ack}, 32'h0);
    check("t2_cpu_rdata", cpu_rdata,        32'hA000_0001);
    check("t2_dma_rd0",   dma_rdata,        32'h0);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check("t2_dma_ack",   {31'b0, dma_ack}, 32'h1);
    check("t2_dma_rdata", dma_rdata,        32'hA000_0002);
    next_cycle();
    dma_req = 1'b0;

    // Single CPU write, same-cycle ack, address aligned
    cpu_req = 1'b1; cpu_addr = 32'h1003; cpu_wdata = 32'h1122_3344; cpu_byteen = 4'hF;
    sample();
    check("t1_cpu_ack",   {31'b0, cpu_ack},    32'h1);
    check("t1_mem_addr",  mem_addr,            32'h1000);
    check("t1_cpu_stall", {31'b0, cpu_stall},  32'h0);
    check("t1_byteen",    {28'b0, mem_byteen}, 32'hF);
    check("t1_wdata",     mem_wdata,           32'h1122_3344);
    next_cycle();
    cpu_req = 1'b0;
    check("t1_mem_write", mem[0], 32'h1122_3344);

    // CPU read with 3 wait states, DMA raised meanwhile
    cpu_req = 1'b1; cpu_addr = 32'hC; cpu_byteen = 4'h0; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("t3_addr",  mem_addr,           32'hC);
      check("t3_stall", {31'b0, cpu_stall}, 32'h1);
      check("t3_dack",  {31'b0, dma_ack},   32'h0);
      next_cycle();
      dma_req = 1'b1; dma_addr = 32'h10; dma_byteen = 4'h0;
    end
    mem_ready = 1'b1;
    sample();
    check("t3_cpu_ack",   {31'b0, cpu_ack},   32'h1);
    check("t3_cpu_rdata", cpu_rdata,          32'hA000_0003);
    check("t3_stall_end", {31'b0, cpu_stall}, 32'h0);
    check("t3_dack_end",  {31'b0, dma_ack},   32'h0);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check("t3_dma_ack",   {31'b0, dma_ack}, 32'h1);
    check("t3_dma_rdata", dma_rdata,        32'hA000_0004);
    next_cycle();
    dma_req = 1'b0;

    // Locked 12-beat DMA burst with CPU waiting: 8 beats, CPU, 4 beats
    dma_addr = 32'h20; dma_byteen = 4'h0; cpu_addr = 32'h24; cpu_byteen = 4'h0;
    for (int c = 0; c <= 12; c++) begin
      dma_req  = 1'b1;
      dma_lock = 1'b1;
      cpu_req  = (c >= 1) && (c <= 8);
      sample();
      check($sformatf("t4_dack_%0d", c),  {31'b0, dma_ack},   {31'b0, c != 8});
      check($sformatf("t4_cack_%0d", c),  {31'b0, cpu_ack},   {31'b0, c == 8});
      check($sformatf("t4_stall_%0d", c), {31'b0, cpu_stall}, {31'b0, (c >= 1) && (c <= 7)});
      next_cycle();
    end
    dma_req = 1'b0; dma_lock = 1'b0; cpu_req = 1'b0;
    next_cycle();

    // Reset in the middle of a stalled DMA write
    dma_req = 1'b1; dma_addr = 32'h28; dma_wdata = 32'hDEAD_BEEF; dma_byteen = 4'hF;
    mem_ready = 1'b0;
    sample();
    check("t5_byteen_gnt", {28'b0, mem_byteen}, 32'hF);
    next_cycle();
    reset = 1'b0; mem_ready = 1'b1;
    sample();
    check("t5_rst_byteen", {28'b0, mem_byteen}, 32'h0);
    check("t5_rst_dack",   {31'b0, dma_ack},    32'h0);
    next_cycle();
    reset = 1'b1; dma_req = 1'b0;
    sample();
    check("t5_idle_byteen", {28'b0, mem_byteen}, 32'h0);
    check("t5_idle_dack",   {31'b0, dma_ack},    32'h0);
    check("t5_mem_kept",    mem[10],             32'hA000_000A);
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h14; cpu_byteen = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h18; dma_byteen = 4'h0;
    sample();
    check("t5_rearb_cack", {31'b0, cpu_ack}, 32'h1);
    check("t5_rearb_dack", {31'b0, dma_ack}, 32'h0);
    check("t5_rearb_crd",  cpu_rdata,        32'hA000_0005);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    check("t5_rearb_dack2", {31'b0, dma_ack}, 32'h1);
    check("t5_rearb_drd",   dma_rdata,        32'hA000_0006);
    next_cycle();
    dma_req = 1'b0;

    // CPU write aborted while waiting on memory
    cpu_req = 1'b1; cpu_addr = 32'h2C; cpu_wdata = 32'h55AA_55AA; cpu_byteen = 4'hF;
    mem_ready = 1'b0;
    sample();
    check("t6_byteen_gnt", {28'b0, mem_byteen}, 32'hF);
    check("t6_stall",      {31'b0, cpu_stall},  32'h1);
    next_cycle();
    cpu_req = 1'b0; mem_ready = 1'b1;
    sample();
    check("t6_abort_cack",   {31'b0, cpu_ack},    32'h0);
    check("t6_abort_byteen", {28'b0, mem_byteen}, 32'h0);
    check("t6_abort_stall",  {31'b0, cpu_stall},  32'h0);
    next_cycle();
    dma_req = 1'b1; dma_addr = 32'h30; dma_byteen = 4'h0;
    sample();
    check("t6_idle_dack", {31'b0, dma_ack}, 32'h1);
    check("t6_mem_kept",  mem[11],          32'hA000_000B);
    next_cycle();
    dma_req = 1'b0;
    next_cycle();

`ifdef ARB_CPU_PRIO_EN
    // Fixed CPU priority: DMA wins only after 16 denied cycles
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_byteen = 4'h0;
    dma_req = 1'b1; dma_addr = 32'h4; dma_byteen = 4'h0;
    for (int c = 0; c <= 16; c++) begin
      sample();
      check($sformatf("prio_cack_%0d", c), {31'b0, cpu_ack}, {31'b0, c != 16});
      check($sformatf("prio_dack_%0d", c), {31'b0, dma_ack}, {31'b0, c == 16});
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    next_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
